// File: rtl/sd_block_fifo_pkg.sv
// Shared defaults and accounting-state encodings for the SD host block FIFO.
package sd_block_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } acct_state_t;

endpackage

// File: rtl/sd_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module sd_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_block_fifo.sv
// Single-clock FIFO between ADMA and DAT logic with watermarks, sticky errors
// and read-side block/transfer accounting.
// Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty;
// read data appears with rd_valid one cycle after the accepted read.
module sd_block_fifo
  import sd_block_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BLK_W    = 12,
  parameter int CNT_W    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              rst_L,
  input  logic              flush,
  input  logic              start,
  input  logic [BLK_W-1:0]  blk_words,
  input  logic [CNT_W-1:0]  blk_count,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              blk_done,
  output logic              xfer_done,
  output logic              overflow,
  output logic              underflow,
  output acct_state_t       acct_state
);

  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;
  logic [BLK_W-1:0] blk_words_q, word_cnt, word_cnt_nxt;
  logic [CNT_W-1:0] blk_count_q, blk_cnt, blk_cnt_nxt;
  logic             count_en, blk_end, last_blk;
  acct_state_t      state_q, state_d;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  assign word_cnt_nxt = word_cnt + BLK_W'(1);
  assign blk_cnt_nxt  = blk_cnt + CNT_W'(1);
  assign count_en     = rd_acc && !start && (state_q == ST_COUNT) && (blk_words_q != '0);
  assign blk_end      = count_en && (word_cnt_nxt == blk_words_q);
  assign last_blk     = (blk_count_q != '0) && (blk_cnt_nxt == blk_count_q);

  assign xfer_done  = (state_q == ST_DONE);
  assign acct_state = state_q;

  sd_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (CLK),
    .rst_n (rst_L),
    .clr   (flush),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_acc;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      blk_words_q <= '0;
      blk_count_q <= '0;
      word_cnt    <= '0;
      blk_cnt     <= '0;
      blk_done    <= 1'b0;
    end else if (flush) begin
      blk_words_q <= '0;
      blk_count_q <= '0;
      word_cnt    <= '0;
      blk_cnt     <= '0;
      blk_done    <= 1'b0;
    end else if (start) begin
      blk_words_q <= blk_words;
      blk_count_q <= blk_count;
      word_cnt    <= '0;
      blk_cnt     <= '0;
      blk_done    <= 1'b0;
    end else begin
      blk_done <= blk_end;
      if (count_en) begin
        word_cnt <= blk_end ? '0 : word_cnt_nxt;
        if (blk_end) blk_cnt <= blk_cnt_nxt;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                        state_d = ST_IDLE;
    else if (start)                                   state_d = ST_COUNT;
    else if (state_q == ST_COUNT && blk_end && last_blk) state_d = ST_DONE;
  end

endmodule

// File: tb/tb_sd_block_fifo.sv
// Directed bench for sd_block_fifo: a DEPTH=16 instance and a DEPTH=4 instance.
module tb_sd_block_fifo;
  import sd_block_fifo_pkg::*;

  logic        CLK, rst_L;
  logic        flush, start, wr_en, rd_en;
  logic [11:0] blk_words;
  logic [15:0] blk_count;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0]  level;
  logic        blk_done, xfer_done, overflow, underflow;
  acct_state_t acct_state;

  logic        s_flush, s_start, s_wr_en, s_rd_en;
  logic [11:0] s_blk_words;
  logic [15:0] s_blk_count;
  logic [31:0] s_wr_data, s_rd_data;
  logic        s_rd_valid, s_full, s_empty, s_almost_full, s_almost_empty;
  logic [2:0]  s_level;
  logic        s_blk_done, s_xfer_done, s_overflow, s_underflow;
  acct_state_t s_acct_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  sd_block_fifo #(.DEPTH(16)) dut (
    .CLK(CLK), .rst_L(rst_L), .flush(flush), .start(start),
    .blk_words(blk_words), .blk_count(blk_count),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .blk_done(blk_done), .xfer_done(xfer_done),
    .overflow(overflow), .underflow(underflow), .acct_state(acct_state)
  );

  sd_block_fifo #(.DEPTH(4)) dut4 (
    .CLK(CLK), .rst_L(rst_L), .flush(s_flush), .start(s_start),
    .blk_words(s_blk_words), .blk_count(s_blk_count),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_almost_full), .almost_empty(s_almost_empty), .level(s_level),
    .blk_done(s_blk_done), .xfer_done(s_xfer_done),
    .overflow(s_overflow), .underflow(s_underflow), .acct_state(s_acct_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    #1;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || level !== 5'd0 ||
        rd_data !== 32'd0 || xfer_done !== 1'b0) begin
      n_err++; $display("FAIL reset_init: empty=%b ae=%b full=%b level=%0d rd_data=%h xd=%b",
                        empty, almost_empty, full, level, rd_data, xfer_done);
    end
    n_vec++;
    repeat (2) @(posedge CLK);
    #1 rst_L = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) write_word(32'h50 + i);
    if (level !== 5'd5) begin n_err++; $display("FAIL pre_reset_level: got %0d want 5", level); end
    n_vec++;
    #2 rst_L = 1'b0;
    #1;
    if (empty !== 1'b1 || level !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL async_reset: empty=%b level=%0d rd_valid=%b ovf=%b want 1/0/0/0",
                        empty, level, rd_valid, overflow);
    end
    n_vec++;
    @(posedge CLK);
    #1 rst_L = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      write_word(i);
      exp_q.push_back(i);
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 14)) begin
        n_err++; $display("FAIL fill_level: level=%0d af=%b want %0d/%b", level, almost_full, i + 1, (i + 1 >= 14));
      end
      n_vec++;
    end
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fill_full: full=%b ovf=%b want 1/0", full, overflow);
    end
    n_vec++;
    write_word(32'hDEAD);
    if (overflow !== 1'b1 || level !== 5'd16) begin
      n_err++; $display("FAIL overflow_set: ovf=%b level=%0d want 1/16", overflow, level);
    end
    n_vec++;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        n_err++; $display("FAIL drain_data[%0d]: valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp_q[0]);
      end
      n_vec++;
      void'(exp_q.pop_front());
    end
    rd_en = 1'b0;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      n_err++; $display("FAIL drain_empty: empty=%b unf=%b want 1/0", empty, underflow);
    end
    n_vec++;
    do_flush();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) write_word(32'hA0 + i);
    wr_en = 1'b1; wr_data = 32'hBEEF; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    if (overflow !== 1'b1 || level !== 5'd15 || rd_valid !== 1'b1 || rd_data !== 32'hA0) begin
      n_err++; $display("FAIL full_simul: ovf=%b level=%0d valid=%b data=%h want 1/15/1/a0",
                        overflow, level, rd_valid, rd_data);
    end
    n_vec++;
    do_flush();
    if (overflow !== 1'b0 || level !== 5'd0 || rd_data !== 32'd0) begin
      n_err++; $display("FAIL flush_clear: ovf=%b level=%0d data=%h want 0/0/0", overflow, level, rd_data);
    end
    n_vec++;
  endtask

  task automatic test_blocks();
    logic exp_bd, exp_xd;
    start = 1'b1; blk_words = 12'd4; blk_count = 16'd2;
    tick();
    start = 1'b0;
    if (acct_state !== ST_COUNT || xfer_done !== 1'b0) begin
      n_err++; $display("FAIL start_state: state=%0d xd=%b want 1/0", acct_state, xfer_done);
    end
    n_vec++;
    for (int i = 0; i < 11; i++) write_word(32'h100 + i);
    rd_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_bd = (i == 3) || (i == 7);
      exp_xd = (i >= 7);
      if (rd_valid !== 1'b1 || rd_data !== 32'h100 + i || blk_done !== exp_bd || xfer_done !== exp_xd) begin
        n_err++; $display("FAIL block_read[%0d]: valid=%b data=%h bd=%b xd=%b want 1/%h/%b/%b",
                          i, rd_valid, rd_data, blk_done, xfer_done, 32'h100 + i, exp_bd, exp_xd);
      end
      n_vec++;
    end
    rd_en = 1'b0;
    tick();
    if (blk_done !== 1'b0 || xfer_done !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL block_hold: bd=%b xd=%b valid=%b want 0/1/0", blk_done, xfer_done, rd_valid);
    end
    n_vec++;
  endtask

  task automatic test_underflow_flush();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h10A) begin
      n_err++; $display("FAIL underflow: unf=%b valid=%b data=%h want 1/0/10a", underflow, rd_valid, rd_data);
    end
    n_vec++;
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    if (underflow !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || xfer_done !== 1'b0 ||
        overflow !== 1'b0 || acct_state !== ST_IDLE) begin
      n_err++; $display("FAIL flush_wr: unf=%b empty=%b level=%0d xd=%b ovf=%b state=%0d want 0/1/0/0/0/0",
                        underflow, empty, level, xfer_done, overflow, acct_state);
    end
    n_vec++;
  endtask

  task automatic test_wrap_depth4();
    s_wr_en = 1'b1; s_wr_data = 32'd1000;
    tick();
    exp_q.push_back(32'd1000);
    s_rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_wr_data = 32'd1001 + i;
      tick();
      exp_q.push_back(32'd1001 + i);
      if (s_rd_valid !== 1'b1 || s_rd_data !== exp_q[0] || s_level !== 3'd1 ||
          s_overflow !== 1'b0 || s_underflow !== 1'b0) begin
        n_err++; $display("FAIL wrap[%0d]: valid=%b data=%0d level=%0d ovf=%b unf=%b want 1/%0d/1/0/0",
                          i, s_rd_valid, s_rd_data, s_level, s_overflow, s_underflow, exp_q[0]);
      end
      n_vec++;
      void'(exp_q.pop_front());
    end
    s_wr_en = 1'b0;
    tick();
    s_rd_en = 1'b0;
    if (s_rd_data !== exp_q[0] || s_empty !== 1'b1 || s_underflow !== 1'b0) begin
      n_err++; $display("FAIL wrap_tail: data=%0d empty=%b unf=%b want %0d/1/0", s_rd_data, s_empty, s_underflow, exp_q[0]);
    end
    n_vec++;
    void'(exp_q.pop_front());
  endtask

  initial begin
    flush = 0; start = 0; wr_en = 0; rd_en = 0; wr_data = 0; blk_words = 0; blk_count = 0;
    s_flush = 0; s_start = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = 0; s_blk_words = 0; s_blk_count = 0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_blocks();
    test_underflow_flush();
    test_wrap_depth4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_block_fifo.md
# sd_block_fifo

Parametrised single-clock data buffer between the ADMA engine and the DAT line logic, replacing the fixed 32-bit buffer with configurable width and depth. It adds watermark flags, sticky overflow/underflow errors, and read-side block accounting. Block accounting raises a per-block pulse and a transfer-complete flag from latched Block Size and Block Count values. It sits inside the SD host on the host clock domain, fed by the DMA on the write side and drained by the DAT serializer on the read side.

## Interface
- DATA_W, 32: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥4.
- BLK_W, 12: width of the block-size-in-words field.
- CNT_W, 16: width of the block count field.
- AF_LEVEL, DEPTH-2: almost_full threshold (level ≥ AF_LEVEL).
- AE_LEVEL, 2: almost_empty threshold (level ≤ AE_LEVEL).
- CLK  in  1  host clock; all logic rising-edge.
- rst_L  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents, pointers, counters and error flags.
- start  in  1  one-cycle pulse; latches blk_words/blk_count and clears block counters and xfer_done.
- blk_words  in  BLK_W  words per block.
- blk_count  in  CNT_W  blocks per transfer; 0 means unbounded.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read word, registered.
- rd_valid  out  1  rd_data holds the word of a read accepted the previous cycle.
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  watermark flags.
- level  out  log2(DEPTH)+1  current occupancy.
- blk_done  out  1  one-cycle pulse, coincident with rd_valid of a block's last word.
- xfer_done  out  1  set when blk_count blocks have been read; held until start/flush.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Write is accepted when wr_en && !full; stores at wr_ptr, and wr_ptr advances modulo DEPTH.
- Write with full is dropped and sets overflow. Simultaneous rd_en does not rescue it.
- Read is accepted when rd_en && !empty; mem[rd_ptr] is registered to rd_data, and rd_ptr advances.
- Read with empty sets underflow; rd_valid stays 0 and rd_data holds its previous value.
- Simultaneous accepted read and write leaves level unchanged.
- Pointers carry one extra MSB. full = (MSBs differ, low bits equal); empty = pointers equal.
- Block accounting operates on accepted reads only:
  - word_cnt increments per read. On reaching latched blk_words it wraps to 0, blk_done asserts with that word's rd_valid, and blk_cnt increments.
  - When blk_cnt reaches latched blk_count ≠ 0, xfer_done sets in the same cycle as blk_done.
  - After xfer_done, further reads still return data, but block counting stops.
  - Latched blk_words = 0 disables blk_done and xfer_done.
- Accounting state machine: IDLE (no start since reset/flush, counting off) → start → COUNT → final block → DONE. start from any state → COUNT. flush → IDLE.
- Priority in one cycle: flush > start > read/write. flush drops same-cycle wr_en/rd_en and sets no error flags.

## Timing
- Reset (rst_L low, asynchronous) and flush values:
  - 1: empty, almost_empty (AE_LEVEL ≥ 0).
  - 0: all other outputs, including rd_data, level, and both pointers.
- Write-to-read latency: a word written in cycle N is readable (empty low) in cycle N+1; its rd_valid is in cycle N+2 at the earliest.
- Read latency: one cycle from accepted rd_en to rd_valid/rd_data.
- Flags and level are registered and reflect all accepted operations of the previous edge.
- The sticky flags assert the cycle after the offending request.
- rst_L release is synchronised by the system; the block requires no internal reset synchroniser.

## Structure
- Shared defines file holds: default DATA_W/DEPTH, and IDLE/COUNT/DONE state encodings (2-bit).
- One sub-module: sd_fifo_mem, a DEPTH×DATA_W array with one synchronous write port and one registered read port. Pointer, flag and accounting logic stay in sd_block_fifo.

## Test plan
- Reset with rst_L low mid-stream after 5 writes → empty=1, level=0, rd_valid=0, overflow=0 immediately, without waiting for a clock edge.
- DEPTH=16: write 16 words 0x0..0xF → full=1 and almost_full from level 14. A 17th write sets overflow, and reading 16 words returns 0x0..0xF in order.
- level=16 with simultaneous wr_en+rd_en → read accepted, write dropped, overflow=1, level=15.
- start with blk_words=4, blk_count=2; stream 8 words through → blk_done pulses on rd_valid of words 4 and 8. xfer_done=1 from word 8 and stays high through 3 more reads.
- rd_en on empty → underflow=1, rd_valid=0. Then flush → underflow=0, empty=1; a flush cycle with wr_en=1 leaves level=0.
- Wrap-around: 40 interleaved write/read pairs at DEPTH=4 → data order preserved, level never exceeds 4, no error flags.
